rca_accumulator: RTL
====================

# rca_accumulator

Sequential accumulation stage built around the combinational `ripple_carry_adder`. It accepts a burst of N-bit operands over a valid/ready stream and sums them through one internal `ripple_carry_adder` instance, with Cin tied to 0. At the end of the burst it presents the registered total, carry count and operand count downstream.

## Interface
Parameters:
- `N`, default 4: operand and accumulator width; passed to the internal `ripple_carry_adder #(N)`.
- `CNT_W`, default 4: width of the carry counter and the operand counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: stage can accept a beat.
- `in_data`, input, N: operand.
- `in_last`, input, 1: final beat of the burst.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, N: accumulator value (low N bits of the total).
- `out_carries`, output, CNT_W: number of adder carry-outs during the burst.
- `out_count`, output, CNT_W: number of beats accepted in the burst.
- `out_ovf`, output, 1: sticky overflow flag for the burst.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD.
- `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD. `out_valid` is 1 only in HOLD.
- A beat is accepted when `in_valid && in_ready`. On acceptance:
  - The adder is driven with A=acc, B=`in_data` and Cin=0.
  - acc <= Sum.
  - count <= count+1, saturating at 2^CNT_W-1. Reaching saturation sets ovf.
  - Carry-out handling is described under Configuration.
- IDLE -> ACCUM on an accepted beat with `in_last`=0.
- IDLE or ACCUM -> HOLD on an accepted beat with `in_last`=1. The last beat is included in the result.
- ACCUM stays in ACCUM while no beat arrives. There is no timeout.
- HOLD -> IDLE when `out_ready`=1. On that edge, acc, carries, count and ovf all clear to 0.
- `out_sum`, `out_carries`, `out_count` and `out_ovf` come directly from the internal registers. They are meaningful only while `out_valid`=1.
- Arithmetic is unsigned. acc wraps modulo 2^N; carries records the wraps.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, and `out_sum`, `out_carries`, `out_count`, `out_ovf` all 0.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so it is visible the following cycle.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- There is exactly one bubble cycle between bursts: `in_ready` returns to 1 in the cycle after the output handshake.
- A beat presented during HOLD is not accepted (`in_ready`=0), whatever the value of `in_last`.
- Reset mid-burst, or in HOLD, discards the partial result. Outputs take their reset values the cycle after `rst_n` is sampled low.
- Reset has priority over any handshake on the same edge.

## Configuration
- `RCA_ACC_SAT_EN` defined (saturating mode): the first carry-out forces acc to all-ones and sets `out_ovf`. acc stays all-ones for the rest of the burst, and `out_carries` stays 0.
- `RCA_ACC_SAT_EN` undefined (counting mode): each carry-out increments carries, saturating at 2^CNT_W-1. Reaching that saturation sets `out_ovf`.

## Test plan
All scenarios use N=4 and CNT_W=4.
1. Beats 1, 2, 3, with `in_last` on 3 and `out_ready`=1 → one cycle after the 3rd beat: `out_valid`=1, `out_sum`=6, `out_carries`=0, `out_count`=3, `out_ovf`=0. `in_ready`=1 again two cycles after the 3rd beat.
2. Beats 13, 11 (last), macro undefined → `out_sum`=8, `out_carries`=1, `out_count`=2, `out_ovf`=0. Same beats with `RCA_ACC_SAT_EN` defined → `out_sum`=15, `out_carries`=0, `out_ovf`=1.
3. Single beat 15 with `in_last`=1, `out_ready` held 0 for 5 cycles → outputs stable at sum 15 and count 1 throughout; `in_ready`=0 and `in_valid` beats are ignored; handshake on cycle 6 → IDLE with all outputs 0.
4. 17 beats of 15, last on the 17th, macro undefined → `out_sum`=15, `out_carries`=15, `out_count`=15 (saturated), `out_ovf`=1.
5. Beats 5, 6, then `rst_n`=0 for 1 cycle, then beats 2 and 2 (last) → `out_sum`=4, `out_count`=2. Nothing from before the reset contributes.
6. `in_valid` gapped, toggling every other cycle, across beats 7, 7, 1 (last) → `out_sum`=15, `out_carries`=0, `out_count`=3. Idle cycles leave the state unchanged.

Source files
------------

// File: rtl/rca_accumulator.sv
// Valid/ready burst accumulator built on a ripple-carry adder.
// Optional saturating mode: define RCA_ACC_SAT_EN.

module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    rca_fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  assign cout = c[N];
endmodule

module rca_accumulator #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [N-1:0]     acc, acc_nxt, add_sum;
  logic [CNT_W-1:0] carries, carries_nxt, count, count_nxt;
  logic             ovf, ovf_nxt, ovf_add, add_co, accept;

  ripple_carry_adder #(.N(N)) u_rca (
    .a(acc), .b(in_data), .cin(1'b0), .sum(add_sum), .cout(add_co)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt     = add_sum;
    carries_nxt = carries;
    ovf_add     = 1'b0;
`ifdef RCA_ACC_SAT_EN
    // once pinned at all-ones every nonzero beat carries again, so it stays pinned
    if (add_co) begin
      acc_nxt = '1;
      ovf_add = 1'b1;
    end
`else
    if (add_co && carries != CNT_MAX) carries_nxt = carries + 1'b1;
    ovf_add = add_co && (carries_nxt == CNT_MAX);
`endif
    count_nxt = (count == CNT_MAX) ? count : count + 1'b1;
    ovf_nxt   = ovf | ovf_add | (count_nxt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      carries <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == HOLD && out_ready) begin
        acc     <= '0;
        carries <= '0;
        count   <= '0;
        ovf     <= 1'b0;
      end else if (accept) begin
        acc     <= acc_nxt;
        carries <= carries_nxt;
        count   <= count_nxt;
        ovf     <= ovf_nxt;
      end
    end
  end

  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_count   = count;
  assign out_ovf     = ovf;
endmodule
